// File: rtl/vga_board_pkg.sv
// vga_board_pkg: shared constants for the VGA board renderer.
//   - cell-state codes, as packed 2 bits per cell in the board vector
//   - 3-bit {r,g,b} colour constants
//   - owner_colour(): maps a cell state to its base colour
package vga_board_pkg;

  typedef logic [1:0] cell_t;
  typedef logic [2:0] rgb_t;   // {r, g, b}

  localparam cell_t EMPTY = 2'b00;
  localparam cell_t RED   = 2'b01;
  localparam cell_t BLUE  = 2'b10;

  localparam rgb_t BLACK   = 3'b000;
  localparam rgb_t WHITE   = 3'b111;
  localparam rgb_t RED_C   = 3'b100;
  localparam rgb_t BLUE_C  = 3'b001;
  localparam rgb_t GREEN_C = 3'b010;

  // Code 2'b11 is not a legal owner and is drawn as an empty cell.
  function automatic rgb_t owner_colour(input cell_t s);
    case (s)
      RED:     return RED_C;
      BLUE:    return BLUE_C;
      default: return BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vga_board_renderer_if.sv
// vga_board_renderer_if: connects the renderer to its sources and its sink.
//   master (game FSM + sync generator side): drives h_counter, v_counter,
//     board, cursor, win_mask; receives vga_r/g/b and de_out.
//   slave (renderer): the reverse.
// GRID_N must match the renderer instance it is connected to.
interface vga_board_renderer_if #(
  parameter int GRID_N = 3
);
  localparam int CELLS = GRID_N * GRID_N;
  localparam int CUR_W = $clog2(CELLS) + 1;

  logic [9:0]         h_counter;
  logic [9:0]         v_counter;
  logic [2*CELLS-1:0] board;
  logic [CUR_W-1:0]   cursor;
  logic [CELLS-1:0]   win_mask;
  logic               vga_r;
  logic               vga_g;
  logic               vga_b;
  logic               de_out;

  modport master (
    output h_counter, v_counter, board, cursor, win_mask,
    input  vga_r, vga_g, vga_b, de_out
  );

  modport slave (
    input  h_counter, v_counter, board, cursor, win_mask,
    output vga_r, vga_g, vga_b, de_out
  );
endinterface

// File: rtl/vga_cell_locator.sv
// vga_cell_locator: maps one raster counter onto a board row/column index.
//   pos     in   counter value (h or v)
//   idx     out  index c where c*CELL <= pos < (c+1)*CELL; the last index
//                also absorbs the SPAN % GRID_N remainder (and any pos >= SPAN)
//   on_line out  pos lies in [c*CELL, c*CELL+LINE_W-1] for some c in 1..GRID_N-1
// Macro GRID_LINES_EN: when undefined on_line is constant 0 and its compare
// logic folds away. Pure combinational; boundaries are elaboration constants.
module vga_cell_locator #(
  parameter  int SPAN   = 640,
  parameter  int GRID_N = 3,
  parameter  int LINE_W = 2,
  localparam int IDX_W  = $clog2(GRID_N)
) (
  input  logic [9:0]       pos,
  output logic [IDX_W-1:0] idx,
  output logic             on_line
);

  localparam int CELL = SPAN / GRID_N;

`ifdef GRID_LINES_EN
  localparam bit LINES_ON = 1'b1;
`else
  localparam bit LINES_ON = 1'b0;
`endif

  // NOTE: every output gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    idx     = '0;
    on_line = 1'b0;
    for (int c = 1; c < GRID_N; c++) begin
      if (int'(pos) >= c * CELL)
        idx = IDX_W'(c);
      if (LINES_ON && int'(pos) >= c * CELL && int'(pos) < c * CELL + LINE_W)
        on_line = 1'b1;
    end
  end

endmodule

// File: rtl/vga_board_renderer.sv
// vga_board_renderer: paints a GRID_N x GRID_N board onto the visible raster.
//   clk  pixel clock
//   rst  asynchronous, active-high reset
//   bus  vga_board_renderer_if.slave: counters, board/cursor/win_mask in;
//        vga_r/g/b and de_out out, 2 clocks after the counters they belong to
// Board, cursor and win_mask are sampled into shadows once per frame, at
// h_counter==0 && v_counter==V_ACTIVE, so a frame never shows a mix of states.
// Macro GRID_LINES_EN: enables white grid lines LINE_W pixels wide.
module vga_board_renderer
  import vga_board_pkg::*;
#(
  parameter int GRID_N       = 3,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int LINE_W       = 2,
  parameter int BLINK_FRAMES = 30
) (
  input logic                clk,
  input logic                rst,
  vga_board_renderer_if.slave bus
);

  localparam int CELLS = GRID_N * GRID_N;
  localparam int IDX_W = $clog2(GRID_N);
  localparam int CUR_W = $clog2(CELLS) + 1;
  localparam int FC_W  = $clog2(BLINK_FRAMES) + 1;

  logic [IDX_W-1:0] col_c, row_c;
  logic             h_line, v_line;

  vga_cell_locator #(.SPAN(H_ACTIVE), .GRID_N(GRID_N), .LINE_W(LINE_W)) u_h_loc (
    .pos(bus.h_counter), .idx(col_c), .on_line(h_line)
  );

  vga_cell_locator #(.SPAN(V_ACTIVE), .GRID_N(GRID_N), .LINE_W(LINE_W)) u_v_loc (
    .pos(bus.v_counter), .idx(row_c), .on_line(v_line)
  );

  // ---- frame snapshot and blink phase ----
  logic [2*CELLS-1:0] board_sh;
  logic [CUR_W-1:0]   cursor_sh;
  logic [CELLS-1:0]   win_sh;
  logic [FC_W-1:0]    frame_cnt;
  logic               blink;
  logic               snap;

  assign snap = (bus.h_counter == 10'd0) && (bus.v_counter == 10'(V_ACTIVE));

  // NOTE: the shadows are reset even though they behave like storage: after a
  // reset the board must read as all-empty until the next snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      board_sh  <= '0;
      cursor_sh <= '0;
      win_sh    <= '0;
      frame_cnt <= '0;
      blink     <= 1'b0;
    end else if (snap) begin
      board_sh  <= bus.board;
      cursor_sh <= bus.cursor;
      win_sh    <= bus.win_mask;
      if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
        frame_cnt <= '0;
        blink     <= ~blink;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // ---- stage 1: geometry ----
  logic [IDX_W-1:0] s1_col, s1_row;
  logic             s1_active, s1_grid;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_col    <= '0;
      s1_row    <= '0;
      s1_active <= 1'b0;
      s1_grid   <= 1'b0;
    end else begin
      s1_col    <= col_c;
      s1_row    <= row_c;
      s1_active <= (bus.h_counter < 10'(H_ACTIVE)) && (bus.v_counter < 10'(V_ACTIVE));
      s1_grid   <= h_line | v_line;
    end
  end

  // ---- stage 2: colour ----
  logic [CUR_W-1:0] cell_idx;
  cell_t            owner;
  logic             is_win;
  rgb_t             colour_next;

  always_comb begin
    cell_idx = CUR_W'(s1_row) * CUR_W'(GRID_N) + CUR_W'(s1_col);
    owner    = EMPTY;
    is_win   = 1'b0;
    // Constant-index mux keeps the part-selects static.
    for (int k = 0; k < CELLS; k++) begin
      if (cell_idx == CUR_W'(k)) begin
        owner  = board_sh[2*k +: 2];
        is_win = win_sh[k];
      end
    end

    colour_next = BLACK;
    if (!s1_active)
      colour_next = BLACK;
    else if (s1_grid)
      colour_next = WHITE;
    else if (is_win && blink)
      colour_next = WHITE;
    else begin
      colour_next = owner_colour(owner);
      // Cursor values >= CELLS never match a cell and so show nothing.
      if (cursor_sh == cell_idx && blink)
        colour_next = colour_next | GREEN_C;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.vga_r  <= 1'b0;
      bus.vga_g  <= 1'b0;
      bus.vga_b  <= 1'b0;
      bus.de_out <= 1'b0;
    end else begin
      bus.vga_r  <= colour_next[2];
      bus.vga_g  <= colour_next[1];
      bus.vga_b  <= colour_next[0];
      bus.de_out <= s1_active;
    end
  end

endmodule
